// File: rtl/down_timer.sv
// Loadable countdown timer: Start/Pause synchronized internally, decrements once per Tick strobe.
// Outputs registered; Start acts two edges after its first sampling edge; no backpressure (Tick is a strobe).
module down_timer #(
  parameter int WIDTH       = 4,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Tick,
  input  logic             Start,
  input  logic             Pause,
  input  logic [WIDTH-1:0] LoadVal,
  output logic [WIDTH-1:0] Count,
  output logic             Borrow,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_d;
  logic             borrow_d, busy_d, done_d;
  logic             s1, s2, s3;
  logic             p1, p2;
  logic             start_pulse, pause_s;

  // s3 only exists to find the rising edge of the synchronized button
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
      p1 <= 1'b0;
      p2 <= 1'b0;
    end else begin
      s1 <= Start;
      s2 <= s1;
      s3 <= s2;
      p1 <= Pause;
      p2 <= p1;
    end
  end

  assign start_pulse = s2 & ~s3;
  assign pause_s     = p2;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      Count   <= '0;
      Borrow  <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state_q <= state_d;
      Count   <= count_d;
      Borrow  <= borrow_d;
      Busy    <= busy_d;
      Done    <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = Count;
    borrow_d = 1'b0;
    if (start_pulse) begin
      count_d = LoadVal;
      if (LoadVal == '0) begin
        state_d  = DONE;
        borrow_d = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (pause_s) begin
            state_d = HOLD;
          end else if (Tick) begin
            if (Count > ONE) begin
              count_d = Count - ONE;
            end else begin
              // zero-crossing: reload only if the fresh LoadVal is non-zero
              borrow_d = 1'b1;
              if (AUTO_RELOAD && (LoadVal != '0)) begin
                count_d = LoadVal;
              end else begin
                count_d = '0;
                state_d = DONE;
              end
            end
          end
        end
        HOLD: begin
          if (!pause_s) state_d = RUN;
        end
        DONE: begin
          count_d = '0;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_comb begin
    busy_d = (state_d == RUN) || (state_d == HOLD);
    done_d = (state_d == DONE);
  end

endmodule

// File: tb/tb_down_timer.sv
// Directed bench for down_timer: vector table on the stop-at-zero build, hand sequences for reload and async reset.
module tb_down_timer;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       Tick = 1'b0;
  logic       Start = 1'b0;
  logic       Pause = 1'b0;
  logic [3:0] LoadVal = 4'd0;
  logic [3:0] count0, count1;
  logic       borrow0, busy0, done0;
  logic       borrow1, busy1, done1;

  int n_checks = 0;
  int n_fail   = 0;

  down_timer #(.WIDTH(4), .AUTO_RELOAD(1'b0)) dut0 (
    .Clk(Clk), .Rst(Rst), .Tick(Tick), .Start(Start), .Pause(Pause), .LoadVal(LoadVal),
    .Count(count0), .Borrow(borrow0), .Busy(busy0), .Done(done0)
  );

  down_timer #(.WIDTH(4), .AUTO_RELOAD(1'b1)) dut1 (
    .Clk(Clk), .Rst(Rst), .Tick(Tick), .Start(Start), .Pause(Pause), .LoadVal(LoadVal),
    .Count(count1), .Borrow(borrow1), .Busy(busy1), .Done(done1)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       tick;
    logic       start;
    logic       pause;
    logic [3:0] ld;
    logic [3:0] cnt;
    logic       brw;
    logic       bsy;
    logic       dn;
  } vec_t;

  vec_t vecs[200];
  int   nv = 0;

  task automatic add(input logic t, input logic s, input logic p, input logic [3:0] ld,
                     input logic [3:0] c, input logic b, input logic bs, input logic d);
    vecs[nv].tick  = t;
    vecs[nv].start = s;
    vecs[nv].pause = p;
    vecs[nv].ld    = ld;
    vecs[nv].cnt   = c;
    vecs[nv].brw   = b;
    vecs[nv].bsy   = bs;
    vecs[nv].dn    = d;
    nv++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Rst = 1'b0; Tick = 1'b0; Start = 1'b0; Pause = 1'b0;
    repeat (2) step();
    Rst = 1'b1;
  endtask

  task automatic chk0(input string tag, input logic [3:0] c, input logic b, input logic bs, input logic d);
    chk({tag, ".count"},  32'(count0),  32'(c));
    chk({tag, ".borrow"}, 32'(borrow0), 32'(b));
    chk({tag, ".busy"},   32'(busy0),   32'(bs));
    chk({tag, ".done"},   32'(done0),   32'(d));
  endtask

  task automatic chk1(input string tag, input logic [3:0] c, input logic b, input logic bs, input logic d);
    chk({tag, ".count"},  32'(count1),  32'(c));
    chk({tag, ".borrow"}, 32'(borrow1), 32'(b));
    chk({tag, ".busy"},   32'(busy1),   32'(bs));
    chk({tag, ".done"},   32'(done1),   32'(d));
  endtask

  initial begin
    // countdown 5..0, tick every 4 cycles
    add(0,1,0,5, 0,0,0,0); add(0,1,0,5, 0,0,0,0); add(0,1,0,5, 5,0,1,0);
    for (int c = 4; c >= 1; c--) begin
      add(1,0,0,5, 4'(c),0,1,0);
      repeat (3) add(0,0,0,5, 4'(c),0,1,0);
    end
    add(1,0,0,5, 0,1,0,1);
    repeat (3) add(0,0,0,5, 0,0,0,1);
    // pause while at 2, ticks ignored in HOLD
    add(0,1,0,3, 0,0,0,1); add(0,1,0,3, 0,0,0,1); add(0,1,0,3, 3,0,1,0);
    add(1,0,0,3, 2,0,1,0);
    add(0,0,1,3, 2,0,1,0); add(0,0,1,3, 2,0,1,0);
    repeat (20) add(1,0,1,3, 2,0,1,0);
    repeat (3) add(0,0,0,3, 2,0,1,0);
    add(1,0,0,3, 1,0,1,0); add(1,0,0,3, 0,1,0,1); add(0,0,0,3, 0,0,0,1);
    // start pulse coinciding with tick at count 4 loads 9
    add(0,1,0,4, 0,0,0,1); add(0,1,0,4, 0,0,0,1); add(0,1,0,4, 4,0,1,0);
    repeat (3) add(0,0,0,4, 4,0,1,0);
    add(0,1,0,9, 4,0,1,0); add(0,1,0,9, 4,0,1,0);
    add(1,1,0,9, 9,0,1,0); add(1,1,0,9, 8,0,1,0);
    // load of zero goes straight to DONE; held button and ticks do nothing
    repeat (3) add(0,0,0,0, 8,0,1,0);
    add(0,1,0,0, 8,0,1,0); add(0,1,0,0, 8,0,1,0); add(0,1,0,0, 0,1,0,1);
    repeat (50) add(1,1,0,0, 0,0,0,1);

    Rst = 1'b0;
    #3;
    chk0("reset0", 4'd0, 1'b0, 1'b0, 1'b0);
    chk1("reset1", 4'd0, 1'b0, 1'b0, 1'b0);
    do_reset();
    step();
    chk0("idle", 4'd0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < nv; i++) begin
      Tick = vecs[i].tick; Start = vecs[i].start; Pause = vecs[i].pause; LoadVal = vecs[i].ld;
      step();
      chk0($sformatf("v%0d", i), vecs[i].cnt, vecs[i].brw, vecs[i].bsy, vecs[i].dn);
    end

    // auto-reload: 2,1,2,1,... then LoadVal=0 at the reload ends in DONE
    do_reset();
    Tick = 1'b0; Start = 1'b1; LoadVal = 4'd2;
    repeat (3) step();
    Start = 1'b0;
    chk1("ar_load", 4'd2, 1'b0, 1'b1, 1'b0);
    Tick = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i % 2 == 0) chk1($sformatf("ar%0d", i), 4'd1, 1'b0, 1'b1, 1'b0);
      else            chk1($sformatf("ar%0d", i), 4'd2, 1'b1, 1'b1, 1'b0);
    end
    LoadVal = 4'd0;
    step();
    chk1("ar_last1", 4'd1, 1'b0, 1'b1, 1'b0);
    step();
    chk1("ar_zero", 4'd0, 1'b1, 1'b0, 1'b1);
    Tick = 1'b0;
    step();
    chk1("ar_done", 4'd0, 1'b0, 1'b0, 1'b1);

    // asynchronous reset mid-RUN, then ticks without a new press
    do_reset();
    Start = 1'b1; LoadVal = 4'd5;
    repeat (3) step();
    Start = 1'b0;
    Tick = 1'b1;
    repeat (2) step();
    Tick = 1'b0;
    chk0("pre_rst", 4'd3, 1'b0, 1'b1, 1'b0);
    #3;
    Rst = 1'b0;
    #1;
    chk0("async_rst", 4'd0, 1'b0, 1'b0, 1'b0);
    #10;
    Rst = 1'b1;
    Tick = 1'b1;
    repeat (5) step();
    chk0("post_rst", 4'd0, 1'b0, 1'b0, 1'b0);
    Tick = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/down_timer.md
Name: down_timer

Overview:
- Loadable countdown timer; the counting-down counterpart of the up counter on the LED board.
- Runs on the fast board clock and decrements once per single-cycle Tick strobe. Tick comes from the divider/rate-select logic.
- Start and Pause come directly from board buttons, so the block synchronizes them internally.
- Count, Borrow and Done drive the LEDs.

Parameters:
- WIDTH, 4, width of Count and LoadVal.
- AUTO_RELOAD, 0, 0 = stop in DONE at zero; 1 = reload LoadVal and keep running.

Ports:
- Clk  input  1  board clock; all logic on rising edge.
- Rst  input  1  asynchronous, active-low reset.
- Tick  input  1  synchronous one-Clk-cycle decrement strobe.
- Start  input  1  raw button, asynchronous; rising edge starts or restarts the timer.
- Pause  input  1  raw button level, asynchronous; high freezes counting.
- LoadVal  input  WIDTH  start value; sampled on each load.
- Count  output  WIDTH  current count.
- Borrow  output  1  one-cycle pulse each time Count reaches zero.
- Busy  output  1  high in RUN and HOLD.
- Done  output  1  high in DONE.

Behaviour:
- Reset (Rst=0, any time, asynchronous): state=IDLE, Count=0, Borrow=0, Busy=0, Done=0, all synchronizer/edge flops=0. Registers leave reset on the first Clk edge after Rst=1.
- Start path:
  - Three-flop chain s1->s2->s3; StartPulse = s2 & ~s3.
  - Start rising before Clk edge k makes StartPulse high after edge k+1.
  - The resulting action takes effect at edge k+2.
  - One pulse per press; holding Start produces no further pulses.
- Pause path: two-flop synchronizer producing PauseS. Same 2-edge latency; used as a level.
- Priority within a cycle: StartPulse > PauseS > Tick.
- Load action (StartPulse in any state): Count<=LoadVal.
  - LoadVal==0 -> DONE, Borrow pulses that cycle.
  - Otherwise -> RUN.
- IDLE: Count holds; Tick and Pause ignored.
- RUN:
  - PauseS=1 -> HOLD, no decrement that cycle.
  - Tick=1 with Count>1 -> Count<=Count-1.
  - Tick=1 with Count==1, AUTO_RELOAD=0 -> Count<=0, Borrow pulse, -> DONE.
  - Tick=1 with Count==1, AUTO_RELOAD=1 -> Count<=LoadVal (fresh sample), Borrow pulse, stay RUN. If that LoadVal==0 -> DONE instead.
- HOLD: Count frozen, Tick ignored. PauseS=0 -> RUN; counting resumes on the next Tick.
- DONE: Count=0, Done=1, Busy=0. Leaves DONE only via StartPulse or reset.
- Outputs: all registered; no combinational path from input to output.
  - Borrow is high exactly one Clk cycle per zero-crossing.
- Count never wraps below 0 (no 0->max underflow). Tick exactly at Count==0 in DONE does nothing.
- Tick held high for several cycles decrements once per cycle. This is legal, not an error.
- Reset mid-RUN returns to IDLE with Count=0; the next press is required to run.

Test Plan:
- Reset, LoadVal=5, press Start, Tick every 4 cycles -> Count 5,4,3,2,1,0. Borrow one cycle at 0, Done=1, Busy=0. Count first shows 5 two edges after the synchronized edge.
- LoadVal=3, run to Count=2, assert Pause for 20 cycles with Ticks -> state HOLD, Count stays 2. Release Pause -> 1,0 on the next two Ticks.
- AUTO_RELOAD=1, LoadVal=2, continuous Ticks -> Count 2,1,2,1,... with a Borrow pulse at each reload, Done stays 0. Then LoadVal=0 at the next reload -> DONE.
- Count=4 in RUN, Start edge timed so StartPulse coincides with Tick, LoadVal=9 -> Count=9, not 3; state RUN.
- LoadVal=0, press Start -> DONE on the load edge, Borrow one pulse, Count=0. Hold Start high 50 cycles -> no further pulses.
- Rst low asynchronously mid-RUN (between Clk edges) -> outputs 0 immediately. After release, Tick has no effect until a new Start.
